// File: rtl/ro_measure_ctrl.sv
// ro_measure_ctrl: ring oscillator sequencer that loads a challenge, settles the ring and counts gated edges.
// Define RO_AVG_EN to run four back-to-back gate windows into a CNT_W+2 bit accumulator, reporting acc >> 2.
module ro_measure_ctrl #(
  parameter int NUM_LUTS      = 20,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 64,
  parameter int GATE_CYCLES   = 1024
) (
  input  logic                static_clk,
  input  logic                rst,
  input  logic                start,
  input  logic [NUM_LUTS-1:0] challenge,
  input  logic                abort,
  output logic                busy,
  output logic [NUM_LUTS-1:0] ro_control,
  output logic                ro_en,
  input  logic                osc_div,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [CNT_W-1:0]    result_count,
  output logic                overflow
);
  // state  | meaning
  // IDLE   | waiting for start; ro_control keeps the last challenge
  // LOAD   | challenge applied to the stages, ring still disabled
  // SETTLE | ring running, edges ignored
  // GATE   | ring running, synchronized rising edges counted
  // DONE   | result presented; result_valid rises one cycle after entry
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, GATE, DONE} state_t;

  localparam int MAX_CYC = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LD   = TW'(GATE_CYCLES - 1);

`ifdef RO_AVG_EN
  localparam int AW = CNT_W + 2;
  logic [1:0] gate_idx;
`else
  localparam int AW = CNT_W;
`endif

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic [AW-1:0] acc;
  logic          timer_tc, ld_settle, ld_gate, last_gate, accept, edge_det;
  logic          s1, s2, s3;

  assign timer_tc     = (timer == '0);
  assign accept       = (state == IDLE) && start;
  assign edge_det     = s2 & ~s3;
  assign busy         = (state != IDLE);
  assign ro_en        = (state == SETTLE) || (state == GATE);
  assign result_count = acc[AW-1 -: CNT_W];

`ifdef RO_AVG_EN
  assign last_gate = (gate_idx == 2'd3);
`else
  assign last_gate = 1'b1;
`endif

  always_ff @(posedge static_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_settle = 1'b0;
    ld_gate   = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = LOAD;
      LOAD:
        if (abort) state_nxt = IDLE;
        else begin
          state_nxt = SETTLE;
          ld_settle = 1'b1;
        end
      SETTLE:
        if (abort) state_nxt = IDLE;
        else if (timer_tc) begin
          state_nxt = GATE;
          ld_gate   = 1'b1;
        end
      GATE:
        if (abort) state_nxt = IDLE;
        else if (timer_tc) begin
          if (last_gate) state_nxt = DONE;
          else           ld_gate   = 1'b1;
        end
      DONE:   if (result_valid && result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge static_clk) begin
    if (rst)               timer <= '0;
    else if (ld_settle)    timer <= SETTLE_LD;
    else if (ld_gate)      timer <= GATE_LD;
    else if (!timer_tc)    timer <= timer - 1'b1;
  end

`ifdef RO_AVG_EN
  always_ff @(posedge static_clk) begin
    if (rst)                             gate_idx <= 2'd0;
    else if (ld_settle)                  gate_idx <= 2'd0;
    else if (ld_gate && state == GATE)   gate_idx <= gate_idx + 2'd1;
  end
`endif

  // The synchronizer free-runs so the first GATE cycle sees a settled history.
  always_ff @(posedge static_clk) begin
    if (rst) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      ro_control   <= '0;
      acc          <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      s1 <= osc_div;
      s2 <= s1;
      s3 <= s2;
      if (accept) begin
        ro_control <= challenge;
        acc        <= '0;
        overflow   <= 1'b0;
      end else if (state == GATE && edge_det) begin
        if (acc == {AW{1'b1}}) overflow <= 1'b1;
        else                   acc      <= acc + 1'b1;
      end
      result_valid <= (state == DONE) && !(result_valid && result_ready);
    end
  end
endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Scoreboard bench for ro_measure_ctrl: nominal instance plus a narrow-counter instance for saturation.
module tb_ro_measure_ctrl;
  localparam int S = 64;
  localparam int G = 1024;
`ifdef RO_AVG_EN
  localparam int NG = 4;
`else
  localparam int NG = 1;
`endif
  localparam int LAT = 2 + S + NG * G;

  logic        static_clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, abort = 1'b0, osc_div = 1'b0, result_ready = 1'b1;
  logic [19:0] challenge = '0;
  logic        busy, ro_en, result_valid, overflow;
  logic [19:0] ro_control;
  logic [15:0] result_count;

  logic        s_start = 1'b0, s_abort = 1'b0, s_ready = 1'b1, osc_fast = 1'b0;
  logic [19:0] s_challenge = 20'h12345;
  logic        s_busy, s_ro_en, s_valid, s_ovf;
  logic [19:0] s_ctrl;
  logic [3:0]  s_count;

  int errors = 0;
  int checks = 0;

  typedef struct {int lo; int hi; logic ovf;} exp_t;
  exp_t sb[$];
  exp_t sb_sat[$];

  ro_measure_ctrl #(.NUM_LUTS(20), .CNT_W(16), .SETTLE_CYCLES(S), .GATE_CYCLES(G)) dut (
    .static_clk(static_clk), .rst(rst), .start(start), .challenge(challenge), .abort(abort),
    .busy(busy), .ro_control(ro_control), .ro_en(ro_en), .osc_div(osc_div),
    .result_valid(result_valid), .result_ready(result_ready), .result_count(result_count),
    .overflow(overflow));

  ro_measure_ctrl #(.NUM_LUTS(20), .CNT_W(4), .SETTLE_CYCLES(4), .GATE_CYCLES(100)) dut_sat (
    .static_clk(static_clk), .rst(rst), .start(s_start), .challenge(s_challenge), .abort(s_abort),
    .busy(s_busy), .ro_control(s_ctrl), .ro_en(s_ro_en), .osc_div(osc_fast),
    .result_valid(s_valid), .result_ready(s_ready), .result_count(s_count),
    .overflow(s_ovf));

  always #5 static_clk = ~static_clk;
  initial begin #3; forever #40 osc_div  = ~osc_div;  end
  initial begin #7; forever #20 osc_fast = ~osc_fast; end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge static_clk);
    #1;
  endtask

  task automatic issue(input logic [19:0] ch);
    start = 1'b1;
    challenge = ch;
    tick();
    start = 1'b0;
    abort = 1'b0;
    challenge = ~ch;
    chk("accept_busy", busy, 1);
    chk("ro_control_latched", ro_control, ch);
    chk("load_ro_en", ro_en, 0);
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!result_valid && k < LAT + 100) begin
      tick();
      k++;
    end
    if (!result_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic measure(input logic [19:0] ch);
    int k;
    sb.push_back('{127, 128, 1'b0});
    issue(ch);
    tick();
    chk("settle_ro_en", ro_en, 1);
    wait_valid(k);
    chk("latency", k + 1, LAT);
    chk("done_ro_en", ro_en, 0);
    chk("ro_control_hold", ro_control, ch);
    tick();
    chk("post_hs_valid", result_valid, 0);
    chk("post_hs_busy", busy, 0);
    chk("idle_ro_control_kept", ro_control, ch);
  endtask

  always @(negedge static_clk) begin
    if (!rst && result_valid && result_ready) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got count=%0d want no result", result_count);
      end else begin
        e = sb.pop_front();
        if (result_count < e.lo || result_count > e.hi || overflow !== e.ovf) begin
          errors++;
          $display("FAIL result: got count=%0d ovf=%0b want %0d..%0d ovf=%0b",
                   result_count, overflow, e.lo, e.hi, e.ovf);
        end
      end
    end
  end

  always @(negedge static_clk) begin
    if (!rst && s_valid && s_ready) begin
      exp_t e;
      checks++;
      if (sb_sat.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sat_result: got count=%0d want no result", s_count);
      end else begin
        e = sb_sat.pop_front();
        if (s_count < e.lo || s_count > e.hi || s_ovf !== e.ovf) begin
          errors++;
          $display("FAIL sat_result: got count=%0d ovf=%0b want %0d..%0d ovf=%0b",
                   s_count, s_ovf, e.lo, e.hi, e.ovf);
        end
      end
    end
  end

  initial begin
    int k;
    int seen;
    repeat (3) tick();
    rst = 1'b0;

    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_outputs", {busy, ro_en, result_valid, overflow, result_count, ro_control}, 0);
    end

    measure(20'hA5A5A);

    // saturation on the 4-bit instance
    sb_sat.push_back('{15, 15, 1'b1});
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    k = 0;
    while (!s_valid && k < 1000) begin
      tick();
      k++;
    end
    if (!s_valid) chk("sat_timeout", 0, 1);
    tick();
    chk("sat_idle_busy", s_busy, 0);

    // backpressure with ignored start pulses
    result_ready = 1'b0;
    sb.push_back('{127, 128, 1'b0});
    issue(20'h0F0F0);
    wait_valid(k);
    for (int i = 0; i < 50; i++) begin
      start = i[0];
      challenge = 20'h33333;
      tick();
      chk_rng("bp_count", result_count, 127, 128);
      chk("bp_valid", result_valid, 1);
      chk("bp_ro_control", ro_control, 20'h0F0F0);
    end
    start = 1'b0;
    result_ready = 1'b1;
    tick();
    chk("bp_release_valid", result_valid, 0);
    chk("bp_release_busy", busy, 0);
    measure(20'h12345);

    // abort ten cycles into GATE
    issue(20'h5555A);
    repeat (S + 1 + 10) tick();
    chk("pre_abort_ro_en", ro_en, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ro_en", ro_en, 0);
    chk("abort_valid", result_valid, 0);
    seen = 0;
    for (int i = 0; i < LAT + 20; i++) begin
      tick();
      if (result_valid) seen++;
    end
    chk("no_result_after_abort", seen, 0);

    // start and abort together in IDLE: start wins, and no stale count leaks through
    abort = 1'b1;
    measure(20'h0A0A0);

    // reset mid-SETTLE
    issue(20'hABCDE);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_settle_outputs", {busy, ro_en, result_valid, overflow, result_count, ro_control}, 0);

    // reset while a result is pending
    result_ready = 1'b0;
    issue(20'h11111);
    wait_valid(k);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_done_outputs", {busy, ro_en, result_valid, overflow, result_count, ro_control}, 0);
    result_ready = 1'b1;

    measure(20'hA5A5A);

    chk("scoreboard_drained", sb.size(), 0);
    chk("sat_scoreboard_drained", sb_sat.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ro_measure_ctrl.md
Name: ro_measure_ctrl

Overview:
Measurement sequencer for one ring oscillator instance.
- Accepts a challenge word from a host and drives it onto the oscillator's per-stage delay controls.
- Enables the ring, waits a settle interval, then counts synchronized rising edges of the (externally divided) oscillator output over a fixed gate window.
- Returns the count through a valid/ready result handshake.
- Sits between the host/UART command logic and the ring_osc array.

Parameters:
- NUM_LUTS, 20, width of challenge and ro_control; one bit per delay stage.
- CNT_W, 16, width of result_count.
- SETTLE_CYCLES, 64, cycles the ring runs before counting; must be >= 1.
- GATE_CYCLES, 1024, length of the counting window in cycles; must be >= 1.

Ports:
- static_clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a measurement; accepted only when busy=0.
- challenge  in  NUM_LUTS  delay-control word, latched at accept.
- abort  in  1  cancel an in-flight measurement.
- busy  out  1  high in any state other than IDLE.
- ro_control  out  NUM_LUTS  registered control word to the ring's delay stages.
- ro_en  out  1  oscillator enable.
- osc_div  in  1  asynchronous divided oscillator output.
- result_valid  out  1  result_count is valid.
- result_ready  in  1  host consumes result.
- result_count  out  CNT_W  edge count.
- overflow  out  1  count saturated during the gate window.

Behaviour:
- Reset values (next edge after rst=1, from any state): state=IDLE; busy=0, ro_control=0, ro_en=0, result_valid=0, result_count=0, overflow=0; all synchronizer/edge flops=0; timer=0.
- States and transitions:
  - IDLE: start=1 → accept. Latch challenge into ro_control, clear count and overflow, go to LOAD.
  - LOAD: exactly 1 cycle, ro_en=0, ro_control stable. Go to SETTLE.
  - SETTLE: ro_en=1 for exactly SETTLE_CYCLES cycles. Go to GATE.
  - GATE: ro_en=1 for exactly GATE_CYCLES cycles; edges counted. Go to DONE.
  - DONE: ro_en=0, result_valid=1, result_count/overflow held stable. On result_valid && result_ready → IDLE; result_valid=0 the next cycle.
- Latency: accept at edge N → first result_valid=1 at edge N+2+SETTLE_CYCLES+GATE_CYCLES.
- start is ignored in every state except IDLE. challenge changes after accept have no effect.
- ro_control holds the last latched challenge until the next accept; it is not cleared on return to IDLE.
- Edge detection:
  - osc_div passes through a 2-flop synchronizer (s1, s2), plus a third flop s3.
  - Rising edge = s2 & ~s3.
  - Synchronizer runs in all states; only edges detected in GATE cycles increment the count.
  - osc_div must be slower than static_clk/2 for a correct count; this is not checked.
- Arithmetic: count saturates at 2^CNT_W-1. An increment attempted at saturation sets overflow=1, which holds until the next accept or reset.
- abort=1 in LOAD, SETTLE or GATE → IDLE next edge with ro_en=0 and result_valid=0. No result is produced; count is discarded.
- abort is ignored in IDLE and DONE. abort and start in the same IDLE cycle: start wins.
- rst mid-operation overrides everything, including abort and a pending DONE handshake.

Optional Feature:
- Macro: RO_AVG_EN.
- Defined:
  - GATE repeats 4 times back to back, with no re-settle between windows.
  - Edges accumulate in a CNT_W+2-bit accumulator that saturates at 2^(CNT_W+2)-1.
  - result_count = accumulator >> 2.
  - overflow set if the accumulator saturates.
  - Latency becomes N+2+SETTLE_CYCLES+4*GATE_CYCLES.
- Undefined: single gate window as described above; no accumulator logic is present.

Test Plan:
- Reset then idle, osc_div toggling → busy=0, ro_en=0, result_valid=0, result_count=0, ro_control=0 for 100 cycles.
- SETTLE=64, GATE=1024, challenge=20'hA5A5A, osc_div period 8 clk (50% duty):
  - ro_control=20'hA5A5A from the cycle after accept.
  - result_valid first high at N+1090.
  - result_count in 127..128; overflow=0.
- CNT_W=4, GATE=100, osc_div period 4 clk → result_count=15, overflow=1.
- Backpressure: hold result_ready=0 for 50 cycles after result_valid → count stable, start pulses ignored. Then ready=1 for 1 cycle → IDLE, and a new start is accepted on the following cycle.
- abort pulsed 10 cycles into GATE → next cycle busy=0, ro_en=0, and result_valid never asserts. A subsequent measurement with osc_div period 8 returns 127..128 (no stale count).
- rst=1 for 1 cycle mid-SETTLE and again in DONE → all outputs at reset values on the next edge. With RO_AVG_EN and osc_div period 8, GATE=1024 → result_count in 127..128.
